// File: rtl/mono_sample_decimator.sv
// Averaging decimator for the mono audio stream. It collects non-overlapping
// windows of 2^DECIM_LOG2 samples and emits the window mean, floored, into the
// sample FIFO together with the peak magnitude seen in that window. When the
// FIFO is full at the moment a window completes, that window is dropped and
// counted.
module mono_sample_decimator #(
    parameter int DATA_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 24,
    parameter int DECIM_LOG2   = 2,
    parameter int OVF_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_sample,
    input  logic                    fifo_full,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_sample,
    output logic [SAMPLE_WIDTH-1:0] window_peak,
    output logic [OVF_WIDTH-1:0]    overflow_count
);

    // The accumulator needs DECIM_LOG2 guard bits so a full window of
    // extreme samples cannot wrap. With DECIM_LOG2 = 0 the counter still
    // needs one bit to be a legal vector; it simply never advances.
    localparam int ACC_W = SAMPLE_WIDTH + DECIM_LOG2;
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

    // |v| in unsigned SAMPLE_WIDTH bits; the most negative value maps to
    // 2^(SAMPLE_WIDTH-1) exactly, which fits as an unsigned number.
    function automatic logic [SAMPLE_WIDTH-1:0] magnitude(
        input logic signed [SAMPLE_WIDTH-1:0] v
    );
        logic [SAMPLE_WIDTH-1:0] u;
        u = v;
        magnitude = u[SAMPLE_WIDTH-1] ? (~u + SAMPLE_WIDTH'(1)) : u;
    endfunction

    // Arithmetic shift floors toward minus infinity; the result always fits
    // back into the sample width because it is a mean of sample values.
    function automatic logic signed [SAMPLE_WIDTH-1:0] window_mean(
        input logic signed [ACC_W-1:0] total
    );
        window_mean = SAMPLE_WIDTH'(total >>> DECIM_LOG2);
    endfunction

    // Place a sample back at the top of the data word with zero padding.
    function automatic logic [DATA_WIDTH-1:0] justify(
        input logic signed [SAMPLE_WIDTH-1:0] v
    );
        justify = '0;
        justify[DATA_WIDTH-1 -: SAMPLE_WIDTH] = v;
    endfunction

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [OVF_WIDTH-1:0] sat_inc(
        input logic [OVF_WIDTH-1:0] v
    );
        sat_inc = (&v) ? v : v + OVF_WIDTH'(1);
    endfunction

    logic signed [ACC_W-1:0]        acc;
    logic [CNT_W-1:0]               cnt;
    logic [SAMPLE_WIDTH-1:0]        pk;

    logic signed [SAMPLE_WIDTH-1:0] s_p0;
    logic [SAMPLE_WIDTH-1:0]        mag_p0;
    logic signed [ACC_W-1:0]        sum_p0;
    logic [SAMPLE_WIDTH-1:0]        peak_p0;
    logic                           accept_p0;
    logic                           last_p0;
    logic                           done_p0;
    logic                           unused_low;

    // ---- stage p0: sample extraction and window arithmetic (combinational)
    assign s_p0      = in_sample[DATA_WIDTH-1 -: SAMPLE_WIDTH];
    assign mag_p0    = magnitude(s_p0);
    assign sum_p0    = acc + ACC_W'(s_p0);
    assign peak_p0   = (mag_p0 > pk) ? mag_p0 : pk;
    assign accept_p0 = enable & in_valid;
    assign last_p0   = (DECIM_LOG2 == 0) ? 1'b1 : (cnt == '1);
    assign done_p0   = accept_p0 & last_p0;

    // Pad bits below the sample field carry no information.
    assign unused_low = ^in_sample;

    // Window state: accumulate, track peak, restart on completion or disable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
            cnt <= '0;
            pk  <= '0;
        end else if (!enable) begin
            acc <= '0;
            cnt <= '0;
            pk  <= '0;
        end else if (in_valid) begin
            if (last_p0) begin
                acc <= '0;
                cnt <= '0;
                pk  <= '0;
            end else begin
                acc <= sum_p0;
                cnt <= cnt + CNT_W'(1);
                pk  <= peak_p0;
            end
        end
    end

    // ---- stage p1: registered emission toward the FIFO, or drop accounting
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid      <= 1'b0;
            out_sample     <= '0;
            window_peak    <= '0;
            overflow_count <= '0;
        end else begin
            out_valid <= 1'b0;
            if (done_p0) begin
                if (!fifo_full) begin
                    out_valid   <= 1'b1;
                    out_sample  <= justify(window_mean(sum_p0));
                    window_peak <= peak_p0;
                end else begin
                    overflow_count <= sat_inc(overflow_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_mono_sample_decimator.sv
// Bench for mono_sample_decimator. Instance a uses the default 4-sample
// window; instance b is a pass-through (window of 1) with an 8-bit drop
// counter so saturation is reachable quickly. A window-level reference model
// stores each window's samples and computes mean/peak with plain arithmetic.
module tb_mono_sample_decimator;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        en_a = 1'b0, vld_a = 1'b0, full_a = 1'b0;
    logic [31:0] in_a = '0;
    logic        ov_a;
    logic [31:0] os_a;
    logic [23:0] pk_a;
    logic [15:0] oc_a;

    logic        en_b = 1'b0, vld_b = 1'b0, full_b = 1'b0;
    logic [31:0] in_b = '0;
    logic        ov_b;
    logic [31:0] os_b;
    logic [23:0] pk_b;
    logic [7:0]  oc_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mono_sample_decimator #(.DATA_WIDTH(32), .SAMPLE_WIDTH(24), .DECIM_LOG2(2), .OVF_WIDTH(16)) dut_a (
        .clk(clk), .resetn(resetn), .enable(en_a), .in_valid(vld_a), .in_sample(in_a),
        .fifo_full(full_a), .out_valid(ov_a), .out_sample(os_a), .window_peak(pk_a),
        .overflow_count(oc_a)
    );

    mono_sample_decimator #(.DATA_WIDTH(32), .SAMPLE_WIDTH(24), .DECIM_LOG2(0), .OVF_WIDTH(8)) dut_b (
        .clk(clk), .resetn(resetn), .enable(en_b), .in_valid(vld_b), .in_sample(in_b),
        .fifo_full(full_b), .out_valid(ov_b), .out_sample(os_b), .window_peak(pk_b),
        .overflow_count(oc_b)
    );

    // ---------------- reference model ----------------
    int          win [2][0:255];
    int          wn [2] = '{0, 0};
    logic        exp_valid [2] = '{1'b0, 1'b0};
    logic [31:0] exp_out [2] = '{32'h0, 32'h0};
    logic [23:0] exp_pk [2] = '{24'h0, 24'h0};
    int          exp_ovf [2] = '{0, 0};

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            wn[i] = 0;
            exp_valid[i] = 1'b0;
            exp_out[i] = '0;
            exp_pk[i] = '0;
            exp_ovf[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input logic en, input logic v,
                              input logic [31:0] word, input logic full);
        int     n, s, a, pk, ovf_max;
        longint sum, q;
        n = (i == 0) ? 4 : 1;
        ovf_max = (i == 0) ? 65535 : 255;
        exp_valid[i] = 1'b0;
        if (!en) begin
            wn[i] = 0;
        end else if (v) begin
            s = int'($signed(word[31:8]));
            win[i][wn[i]] = s;
            wn[i]++;
            if (wn[i] == n) begin
                sum = 0;
                pk = 0;
                for (int k = 0; k < n; k++) begin
                    sum += win[i][k];
                    a = (win[i][k] < 0) ? -win[i][k] : win[i][k];
                    if (a > pk) pk = a;
                end
                if (full) begin
                    if (exp_ovf[i] < ovf_max) exp_ovf[i]++;
                end else begin
                    q = sum / n;
                    if ((sum % n != 0) && (sum < 0)) q = q - 1;
                    exp_valid[i] = 1'b1;
                    exp_out[i] = {q[23:0], 8'h00};
                    exp_pk[i] = pk[23:0];
                end
                wn[i] = 0;
            end
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            model_clear();
        end else begin
            model_step(0, en_a, vld_a, in_a, full_a);
            model_step(1, en_b, vld_b, in_b, full_b);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all();
        chk("a_valid", 64'(ov_a), 64'(exp_valid[0]));
        chk("a_sample", 64'(os_a), 64'(exp_out[0]));
        chk("a_peak", 64'(pk_a), 64'(exp_pk[0]));
        chk("a_ovf", 64'(oc_a), 64'(exp_ovf[0]));
        chk("b_valid", 64'(ov_b), 64'(exp_valid[1]));
        chk("b_sample", 64'(os_b), 64'(exp_out[1]));
        chk("b_peak", 64'(pk_b), 64'(exp_pk[1]));
        chk("b_ovf", 64'(oc_b), 64'(exp_ovf[1]));
    endtask

    function automatic logic [31:0] mkword(input int s);
        logic [31:0] w;
        w[31:8] = s[23:0];
        w[7:0]  = 8'($urandom);
        return w;
    endfunction

    // One clock with both instances' inputs applied, then a full check.
    task automatic cyc(input logic ea, input logic va, input int sa, input logic fa,
                       input logic eb, input logic vb, input int sb, input logic fb);
        en_a = ea; vld_a = va; in_a = mkword(sa); full_a = fa;
        en_b = eb; vld_b = vb; in_b = mkword(sb); full_b = fb;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cyc_a(input logic e, input logic v, input int s, input logic f);
        cyc(e, v, s, f, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic cyc_b(input logic e, input logic v, input int s, input logic f);
        cyc(1'b1, 1'b0, 0, 1'b0, e, v, s, f);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [3:0][23:0] s;
        logic             full;
        logic [31:0]      out;
        logic [23:0]      pk;
        logic             pulse;
        logic [15:0]      ovf;
    } vec_t;

    vec_t tbl [6];

    task automatic set_vec(input int i, input int s0, input int s1, input int s2, input int s3,
                           input logic f, input logic [31:0] o, input logic [23:0] p,
                           input logic pl, input logic [15:0] ov);
        tbl[i].s[0] = s0[23:0];
        tbl[i].s[1] = s1[23:0];
        tbl[i].s[2] = s2[23:0];
        tbl[i].s[3] = s3[23:0];
        tbl[i].full = f;
        tbl[i].out = o;
        tbl[i].pk = p;
        tbl[i].pulse = pl;
        tbl[i].ovf = ov;
    endtask

    initial begin
        set_vec(0, 100, 200, 300, 400, 1'b0, 32'h0000FA00, 24'd400, 1'b1, 16'd0);
        set_vec(1, -1, -2, -3, -4, 1'b0, 32'hFFFFFD00, 24'd4, 1'b1, 16'd0);
        set_vec(2, -8388608, -8388608, -8388608, -8388608, 1'b0, 32'h80000000, 24'h800000, 1'b1, 16'd0);
        set_vec(3, 8388607, 8388607, 8388607, 8388607, 1'b0, 32'h7FFFFF00, 24'h7FFFFF, 1'b1, 16'd0);
        set_vec(4, 1, 2, 3, 4, 1'b1, 32'h7FFFFF00, 24'h7FFFFF, 1'b0, 16'd1);
        set_vec(5, 10, 10, 10, 10, 1'b0, 32'h00000A00, 24'd10, 1'b1, 16'd1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_sample", 64'(os_a), 64'h0);
        #3 resetn = 1'b1;

        // Table-driven windows on instance a
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++)
                cyc_a(1'b1, 1'b1, int'($signed(tbl[i].s[k])), (k == 3) ? tbl[i].full : 1'b0);
            chk($sformatf("tbl%0d_valid", i), 64'(ov_a), 64'(tbl[i].pulse));
            chk($sformatf("tbl%0d_sample", i), 64'(os_a), 64'(tbl[i].out));
            chk($sformatf("tbl%0d_peak", i), 64'(pk_a), 64'(tbl[i].pk));
            chk($sformatf("tbl%0d_ovf", i), 64'(oc_a), 64'(tbl[i].ovf));
            cyc_a(1'b1, 1'b0, 0, 1'b0);
            chk($sformatf("tbl%0d_pulse_end", i), 64'(ov_a), 64'h0);
        end

        // Reset mid-window, asserted between clock edges
        cyc_a(1'b1, 1'b1, 8, 1'b0);
        cyc_a(1'b1, 1'b1, 8, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_sample", 64'(os_a), 64'h0);
        chk("midrst_peak", 64'(pk_a), 64'h0);
        chk("midrst_ovf", 64'(oc_a), 64'h0);
        check_all();
        #2 resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc_a(1'b1, 1'b1, 8, 1'b0);
            chk("midrst_nopulse", 64'(ov_a), 64'h0);
        end
        cyc_a(1'b1, 1'b1, 8, 1'b0);
        chk("midrst_valid", 64'(ov_a), 64'h1);
        chk("midrst_out", 64'(os_a), 64'h00000800);

        // Enable gating discards a partial window
        for (int k = 0; k < 3; k++) cyc_a(1'b1, 1'b1, 5, 1'b0);
        cyc_a(1'b0, 1'b1, 7, 1'b0);
        cyc_a(1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc_a(1'b1, 1'b1, 20, 1'b0);
            chk("en_nopulse", 64'(ov_a), 64'h0);
        end
        cyc_a(1'b1, 1'b1, 20, 1'b0);
        chk("en_valid", 64'(ov_a), 64'h1);
        chk("en_out", 64'(os_a), 64'h00001400);

        // Pass-through instance: consecutive pulses
        cyc_b(1'b1, 1'b1, 5, 1'b0);
        chk("pt0_valid", 64'(ov_b), 64'h1);
        chk("pt0_out", 64'(os_b), 64'h00000500);
        cyc_b(1'b1, 1'b1, -7, 1'b0);
        chk("pt1_valid", 64'(ov_b), 64'h1);
        chk("pt1_out", 64'(os_b), 64'hFFFFF900);
        chk("pt1_peak", 64'(pk_b), 64'd7);

        // Drop-counter saturation on the pass-through instance
        for (int k = 0; k < 300; k++) cyc_b(1'b1, 1'b1, int'($urandom_range(0, 1000)), 1'b1);
        chk("sat_ovf", 64'(oc_b), 64'hFF);
        chk("sat_hold", 64'(os_b), 64'hFFFFF900);

        // Fresh start, then randomized traffic on both instances
        #2 resetn = 1'b0;
        #3 resetn = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            int sa, sb;
            sa = int'($signed(24'($urandom)));
            sb = int'($signed(24'($urandom)));
            if ($urandom_range(0, 15) == 0) sa = -8388608;
            if ($urandom_range(0, 15) == 0) sb = 8388607;
            cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), sa, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 19) != 0), ($urandom_range(0, 1) != 0), sb, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
